// File: rtl/imm_extend_stage.sv
// Immediate extender (zero/sign/upper/upper-signed) feeding a 2-entry skid FIFO toward EXE.
// Latency: 1 cycle, so an item pushed at edge N is head of out_imm right after edge N.
// Backpressure: in_ready is registered and drops when both entries are full; the head holds while out_ready=0.
// Optional IMM_TRUNC_FLAG_EN adds out_trunc, flagging upper-mode results that lost significant bits.
module imm_extend_stage #(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 8,
  parameter int UP_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
`ifdef IMM_TRUNC_FLAG_EN
  ,
  output logic             out_trunc
`endif
);

  // Reject parameter combinations the extender cannot represent.
  if (IN_W < 1 || IN_W > OUT_W || UP_SHIFT < 0 || UP_SHIFT >= OUT_W) begin : g_bad_params
    $error("imm_extend_stage: need 1 <= IN_W <= OUT_W and 0 <= UP_SHIFT < OUT_W");
  end

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_UPSGN = 2'b11;

  // Extension datapath: plain widenings of the raw field.
  logic [OUT_W-1:0] zext_w;
  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] upper_z_w;
  logic [OUT_W-1:0] upper_s_w;
  logic [OUT_W-1:0] ext_d;

  assign zext_w = OUT_W'(in_imm);
  assign sext_w = OUT_W'($signed(in_imm));

`ifdef IMM_TRUNC_FLAG_EN
  // Shift into a double-width vector so the bits pushed past OUT_W stay visible.
  localparam int WIDE_W = 2 * OUT_W;
  logic [WIDE_W-1:0] zwide_w;
  logic [WIDE_W-1:0] swide_w;
  logic              trunc_d;

  assign zwide_w   = WIDE_W'(in_imm) << UP_SHIFT;
  assign swide_w   = WIDE_W'($signed(in_imm)) << UP_SHIFT;
  assign upper_z_w = zwide_w[OUT_W-1:0];
  assign upper_s_w = swide_w[OUT_W-1:0];

  // Truncation flag: upper loses any set bit; upper-signed loses any bit unlike the new MSB.
  always_comb begin
    trunc_d = 1'b0;
    case (in_mode)
      MODE_UPPER: trunc_d = |zwide_w[WIDE_W-1:OUT_W];
      MODE_UPSGN: trunc_d = (swide_w[WIDE_W-1:OUT_W] != {OUT_W{swide_w[OUT_W-1]}});
      default:    trunc_d = 1'b0;
    endcase
  end
`else
  assign upper_z_w = zext_w << UP_SHIFT;
  assign upper_s_w = sext_w << UP_SHIFT;
`endif

  // Mode select: the entry is stored already extended so the FIFO read side is a plain mux.
  always_comb begin
    ext_d = zext_w;
    case (in_mode)
      MODE_ZERO:  ext_d = zext_w;
      MODE_SIGN:  ext_d = sext_w;
      MODE_UPPER: ext_d = upper_z_w;
      MODE_UPSGN: ext_d = upper_s_w;
      default:    ext_d = zext_w;
    endcase
  end

  // FIFO state.
  logic [OUT_W-1:0] mem_q [2];
`ifdef IMM_TRUNC_FLAG_EN
  logic             trunc_mem_q [2];
`endif
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic             in_ready_q;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // Occupancy next-state; push+pop at count 1 leaves it at 1 with the new item as head.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and the registered ready; reset discards anything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
`ifdef IMM_TRUNC_FLAG_EN
      trunc_mem_q[0] <= 1'b0;
      trunc_mem_q[1] <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (push) begin
        mem_q[wr_ptr_q] <= ext_d;
`ifdef IMM_TRUNC_FLAG_EN
        trunc_mem_q[wr_ptr_q] <= trunc_d;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_imm   = mem_q[rd_ptr_q];
`ifdef IMM_TRUNC_FLAG_EN
  assign out_trunc = trunc_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: directed scenarios plus random traffic against a queue model.
// The model computes extensions with integer arithmetic and tracks occupancy as a queue.
// With IMM_TRUNC_FLAG_EN defined, out_trunc is also checked, plus a 6-bit-output instance.
module tb_imm_extend_stage;
  localparam int IN_W  = 3;
  localparam int OUT_W = 8;
  localparam int S     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
`ifdef IMM_TRUNC_FLAG_EN
  logic             out_trunc;
`endif

  always #5 clk = ~clk;

  imm_extend_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .UP_SHIFT(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm)
`ifdef IMM_TRUNC_FLAG_EN
    , .out_trunc(out_trunc)
`endif
  );

`ifdef IMM_TRUNC_FLAG_EN
  logic            s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_trunc;
  logic [IN_W-1:0] s_in_imm;
  logic [1:0]      s_in_mode;
  logic [5:0]      s_out_imm;

  imm_extend_stage #(.IN_W(3), .OUT_W(6), .UP_SHIFT(4)) dut6 (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_imm(s_in_imm), .in_mode(s_in_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_imm(s_out_imm), .out_trunc(s_out_trunc)
  );
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [OUT_W-1:0] q [$];
  logic             tq [$];
  logic             exp_rdy = 1'b0;
  logic             known   = 1'b0;
  logic             last_rst = 1'b0;

  // Mathematical value of the immediate before truncation to OUT_W.
  function automatic longint full_val(int imm, int mode);
    longint v;
    v = imm;
    if ((mode % 2) == 1 && imm >= (1 << (IN_W - 1))) v = imm - (1 << IN_W);
    if (mode >= 2) v = v * (longint'(1) << S);
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] ref_imm(int imm, int mode);
    longint v;
    longint m;
    m = longint'(1) << OUT_W;
    v = full_val(imm, mode) % m;
    if (v < 0) v = v + m;
    return OUT_W'(v);
  endfunction

  // Flag set when the exact value does not fit the result's unsigned/signed range.
  function automatic logic ref_trunc(int imm, int mode);
    longint v;
    v = full_val(imm, mode);
    if (mode == 2) return (v >= (longint'(1) << OUT_W));
    if (mode == 3) return (v < -(longint'(1) << (OUT_W - 1))) || (v >= (longint'(1) << (OUT_W - 1)));
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check before the edge, advance the model at the edge.
  task automatic cyc(input logic v, input int imm, input int mode, input logic ordy, input logic rn);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_imm    = imm[IN_W-1:0];
    in_mode   = mode[1:0];
    out_ready = ordy;
    rst_n     = rn;
    @(negedge clk);
    if (known) begin
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("out_imm", out_imm, q[0]);
`ifdef IMM_TRUNC_FLAG_EN
        check("out_trunc", out_trunc, tq[0]);
`endif
      end
      if (last_rst) check("rst_out_imm", out_imm, 0);
    end
    do_push = v && exp_rdy;
    do_pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    known = 1'b1;
    if (!rn) begin
      q.delete();
      tq.delete();
      exp_rdy  = 1'b0;
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (do_pop) begin
        void'(q.pop_front());
        void'(tq.pop_front());
      end
      if (do_push) begin
        q.push_back(ref_imm(imm, mode));
        tq.push_back(ref_trunc(imm, mode));
      end
      exp_rdy = (q.size() != 2);
    end
    #1;
  endtask

  initial begin
    in_valid = 0; in_imm = 0; in_mode = 0; out_ready = 0; rst_n = 0;
`ifdef IMM_TRUNC_FLAG_EN
    s_rst_n = 0; s_in_valid = 0; s_in_imm = 0; s_in_mode = 0; s_out_ready = 1;
`endif
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);

    // Zero and sign extension, visible one edge after the push.
    cyc(1, 5, 0, 1, 1); check("t1_zero", out_imm, 8'h05);
    cyc(1, 5, 1, 1, 1); check("t1_sign_neg", out_imm, 8'hFD);
    cyc(1, 3, 1, 1, 1); check("t1_sign_pos", out_imm, 8'h03);
    // Upper modes.
    cyc(1, 5, 2, 1, 1); check("t2_upper", out_imm, 8'h50);
    cyc(1, 5, 3, 1, 1); check("t2_upsgn", out_imm, 8'hD0);
    cyc(1, 0, 3, 1, 1); check("t2_upsgn0", out_imm, 8'h00);
    cyc(0, 0, 0, 1, 1);

    // Stall: A and B accepted, C held off, then ordered drain.
    cyc(1, 1, 0, 0, 1);
    cyc(1, 2, 0, 0, 1); check("t3_head_a", out_imm, 8'h01);
    cyc(1, 3, 0, 0, 1); check("t3_rdy_low", in_ready, 1'b0);
    cyc(1, 3, 0, 0, 1);
    cyc(1, 3, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);

    // Streaming at one item per cycle.
    for (int i = 0; i < 8; i++) cyc(1, i, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);

    // Reset with two entries buffered.
    cyc(1, 6, 1, 0, 1);
    cyc(1, 7, 2, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) != 0));
    end

`ifdef IMM_TRUNC_FLAG_EN
    // Narrow output: truncation flag against the documented cases.
    @(negedge clk); s_rst_n = 0;
    @(posedge clk); #1 s_rst_n = 1;
    @(posedge clk); #1;
    s_in_valid = 1; s_in_imm = 3'b101; s_in_mode = 2'b10;
    @(posedge clk); #1;
    check("t6_up_imm", s_out_imm, 6'b010000); check("t6_up_tr", s_out_trunc, 1'b1);
    s_in_imm = 3'b001; s_in_mode = 2'b10;
    @(posedge clk); #1;
    check("t6_up1_imm", s_out_imm, 6'b010000); check("t6_up1_tr", s_out_trunc, 1'b0);
    s_in_imm = 3'b111; s_in_mode = 2'b11;
    @(posedge clk); #1;
    check("t6_us_imm", s_out_imm, 6'b110000); check("t6_us_tr", s_out_trunc, 1'b0);
    s_in_valid = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
